// File: rtl/uart_rx_if.sv
// Receiver-side byte interface: the serial line in, and the framed byte plus its pulses out.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  // master drives the line and consumes characters; slave is the receiver core
  modport master (output rx, input dout, input rx_done_tick, input frame_err);
  modport slave  (input rx, output dout, output rx_done_tick, output frame_err);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver with 16x oversampling, LSB-first framing and
// single-cycle done / framing-error pulses.
module uart_rx_core #(
  parameter int CLK_DIV = 54,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state_reg;
  logic            rx_meta_reg;
  logic            rx_s_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic            s_tick;
  logic [3:0]      s_cnt_reg;
  logic [NW-1:0]   n_reg;
  logic [DBIT-1:0] shift_reg;
  logic [DBIT-1:0] dout_reg;
  logic            rx_done_tick_reg;
  logic            frame_err_reg;

  // Two-flop synchroniser; idles high so reset does not look like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= bus.rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign s_tick = (tick_cnt_reg == TW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || s_tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      s_cnt_reg        <= '0;
      n_reg            <= '0;
      shift_reg        <= '0;
      dout_reg         <= '0;
      rx_done_tick_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      rx_done_tick_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg <= START;
            s_cnt_reg <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt_reg == 4'd7) begin
              if (!rx_s_reg) begin
                state_reg <= DATA;
                s_cnt_reg <= '0;
                n_reg     <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt_reg == 4'd15) begin
              shift_reg <= {rx_s_reg, shift_reg[DBIT-1:1]};
              s_cnt_reg <= '0;
              if (n_reg == NW'(DBIT - 1)) begin
                state_reg <= STOP;
              end else begin
                n_reg <= n_reg + 1'b1;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt_reg == 4'(SB_TICK - 1)) begin
              if (rx_s_reg) begin
                dout_reg         <= shift_reg;
                rx_done_tick_reg <= 1'b1;
                state_reg        <= IDLE;
              end else begin
                // A held-low line must not be decoded as a stream of zero bytes
                frame_err_reg <= 1'b1;
                state_reg     <= WAIT_IDLE;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = rx_done_tick_reg;
  assign bus.frame_err    = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core: serial frames are generated at the
// bit level and the received bytes are compared with the queue of bytes sent.
module tb_uart_rx_core;

  localparam int CLK_DIV = 4;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int BIT     = 16 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_rx_core #(
    .CLK_DIV(CLK_DIV),
    .DBIT   (DBIT),
    .SB_TICK(SB_TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         stray_cnt = 0;
  logic [7:0] dout_prev = 8'h00;
  logic       rst_prev = 1'b1;

  always @(posedge clk) cyc++;

  // Observer: record every character pulse and watch output invariants
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      got_q.push_back(bus.dout);
      got_t.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.rx_done_tick === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    if (!rst && !rst_prev && bus.dout !== dout_prev && bus.rx_done_tick !== 1'b1) stray_cnt++;
    dout_prev = bus.dout;
    rst_prev  = rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: start, DBIT data bits LSB first, one stop bit of value stop_val.
  // With jitter, every internal bit boundary moves by +/-24 clk.
  task automatic drive_frame(input logic [7:0] b, input logic stop_val, input bit jitter);
    int off[11];
    logic bits[10];
    off[0]  = 0;
    off[10] = 0;
    for (int k = 1; k < 10; k++) off[k] = jitter ? (($urandom_range(0, 1) == 1) ? 24 : -24) : 0;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k + 1] = b[k];
    bits[9] = stop_val;
    for (int k = 0; k < 10; k++) begin
      bus.rx = bits[k];
      wait_clk(BIT + off[k + 1] - off[k]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    exp_q.push_back(b);
    drive_frame(b, 1'b1, jitter);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int lat;
    int gap;
    logic [7:0] rb;

    bus.rx = 1'b1;
    rst    = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    check("reset_dout", bus.dout, 8'h00);
    check("reset_done", bus.rx_done_tick, 1'b0);
    check("reset_ferr", bus.frame_err, 1'b0);
    wait_clk(100);

    // Single character with idle gaps, plus first-pulse latency from the start edge
    got_q.delete(); got_t.delete();
    t0 = cyc;
    send_byte(8'h41, 1'b0);
    wait_clk(200);
    lat = (got_t.size() > 0) ? got_t[0] - t0 : -1;
    check_range("s1_latency", lat, 600, 624);
    compare_frames("s1");
    check("s1_ferr", err_cnt, 0);

    // Back-to-back with no idle gap
    send_byte(8'h04, 1'b0);
    send_byte(8'hA5, 1'b0);
    wait_clk(200);
    gap = (got_t.size() > 1) ? got_t[1] - got_t[0] : -1;
    check_range("s2_spacing", gap, 636, 644);
    compare_frames("s2");

    // Short glitch must be rejected silently
    bus.rx = 1'b0;
    wait_clk(20);
    bus.rx = 1'b1;
    wait_clk(100);
    check("s3_glitch_done", got_q.size(), 0);
    check("s3_glitch_ferr", err_cnt, 0);
    send_byte(8'h3C, 1'b0);
    wait_clk(100);
    compare_frames("s3");

    // Bad stop bit followed by a break
    drive_frame(8'h55, 1'b0, 1'b0);
    wait_clk(5 * BIT);
    check("s4_ferr_once", err_cnt, 1);
    check("s4_no_byte", got_q.size(), 0);
    check("s4_dout_kept", bus.dout, 8'h3C);
    bus.rx = 1'b1;
    wait_clk(200);
    check("s4_ferr_after_idle", err_cnt, 1);
    send_byte(8'h12, 1'b0);
    wait_clk(100);
    compare_frames("s4");

    // Reset in the middle of data bit 3 of 0xFF
    bus.rx = 1'b0;
    wait_clk(BIT);
    bus.rx = 1'b1;
    wait_clk(3 * BIT + BIT / 2);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(5 * BIT + BIT / 2 + 100);
    check("s5_no_byte", got_q.size(), 0);
    check("s5_ferr", err_cnt, 1);
    check("s5_dout_reset", bus.dout, 8'h00);
    send_byte(8'h81, 1'b0);
    wait_clk(100);
    compare_frames("s5");

    // Jittered edges, then random bytes back-to-back
    send_byte(8'hC3, 1'b1);
    wait_clk(100);
    compare_frames("s6_jitter");
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, (i % 2) == 1);
    end
    wait_clk(200);
    compare_frames("s7_random");

    check("final_ferr", err_cnt, 1);
    check("never_both", both_cnt, 0);
    check("dout_stable", stray_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
